// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: states, instruction
// classes, datapath mux codes and trap causes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_WB     = 4'd5,
    ST_BRANCH = 4'd6,
    ST_JUMP   = 4'd7,
    ST_HALT   = 4'd8,
    ST_TRAP   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR,
    CLS_LUI, CLS_AUIPC, CLS_ALUIMM, CLS_ALUREG, CLS_SYSTEM
  } cls_e;

  typedef struct packed {
    logic load, store, branch, jal, jalr, lui, auipc, alu_imm, alu_reg, system;
  } cls_onehot_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [1:0] SRCA_RS1   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_PASSB  = 2'b11;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_ECALL   = 2'b10;
  localparam logic [1:0] CAUSE_BUS     = 2'b11;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Resolves multiple asserted class bits to one class.
  function automatic cls_e pick_class(cls_onehot_t oh);
    if (oh.load)         return CLS_LOAD;
    else if (oh.store)   return CLS_STORE;
    else if (oh.branch)  return CLS_BRANCH;
    else if (oh.jal)     return CLS_JAL;
    else if (oh.jalr)    return CLS_JALR;
    else if (oh.lui)     return CLS_LUI;
    else if (oh.auipc)   return CLS_AUIPC;
    else if (oh.alu_imm) return CLS_ALUIMM;
    else if (oh.alu_reg) return CLS_ALUREG;
    else if (oh.system)  return CLS_SYSTEM;
    else                 return CLS_NONE;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// drives the strobes and mux selects, the datapath side drives decode/ready.
interface multicycle_control_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] instr;
  logic alu_reg, alu_imm, branch, jal, jalr, lui, auipc, load, store, system;
  logic mem_ready, branch_taken;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, mem_addr_sel;
  logic [1:0] pc_src, alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic halt, trap;
  logic [1:0] trap_cause;
  logic [3:0] state;

  modport master (
    input  instr, alu_reg, alu_imm, branch, jal, jalr, lui, auipc, load, store, system,
           mem_ready, branch_taken,
    output pc_write, ir_write, reg_write, mem_read, mem_write, mem_addr_sel,
           pc_src, alu_src_a, alu_src_b, result_src, alu_op, imm_src,
           halt, trap, trap_cause, state
  );

  modport slave (
    output instr, alu_reg, alu_imm, branch, jal, jalr, lui, auipc, load, store, system,
           mem_ready, branch_taken,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, mem_addr_sel,
           pc_src, alu_src_a, alu_src_b, result_src, alu_op, imm_src,
           halt, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts memory wait cycles; expired_o flags that MEM_TIMEOUT waits have elapsed.
// MEM_TIMEOUT = 0 disables expiry.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);
  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] CNT_MAX = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT) : '1;

  logic [TW-1:0] cnt_q, cnt_d;

  // Saturating: the count parks at CNT_MAX instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (count_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (MEM_TIMEOUT > 0) && (cnt_q == CNT_MAX);
endmodule

// File: rtl/multicycle_control.sv
// RV32I multi-cycle control FSM sharing one memory port and one ALU.
// FETCH fetch+PC+=4 | DECODE latch class | EXEC ALU op | MEM_RD/MEM_WR data access
// WB reg write | BRANCH cond PC update | JUMP link+PC | HALT ebreak | TRAP fault
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);
  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  logic [1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] instr_w;
  logic [31:0] ir;
  cls_onehot_t oh;
  logic expired, wait_st, is_ecall, is_ebreak;

  assign instr_w = bus.instr;
  assign ir = instr_w[31:0];
  assign oh = {bus.load, bus.store, bus.branch, bus.jal, bus.jalr,
               bus.lui, bus.auipc, bus.alu_imm, bus.alu_reg, bus.system};
  assign is_ecall  = (ir[31:7] == 25'd0) && (ir[6:0] == OPC_SYSTEM);
  assign is_ebreak = (ir[31:21] == 11'd0) && ir[20] && (ir[19:7] == 13'd0) &&
                     (ir[6:0] == OPC_SYSTEM);
  assign wait_st = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_d != state_q),
    .count_i   (wait_st && !bus.mem_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    case (state_q)
      ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
        if (bus.mem_ready) begin
          if (state_q == ST_FETCH)       state_d = ST_DECODE;
          else if (state_q == ST_MEM_RD) state_d = ST_WB;
          else                           state_d = ST_FETCH;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      ST_DECODE: begin
        cls_d = pick_class(oh);
        case (cls_d)
          CLS_LOAD, CLS_STORE, CLS_LUI, CLS_AUIPC, CLS_ALUIMM, CLS_ALUREG: state_d = ST_EXEC;
          CLS_BRANCH:        state_d = ST_BRANCH;
          CLS_JAL, CLS_JALR: state_d = ST_JUMP;
          CLS_SYSTEM: begin
            if (is_ecall) begin
              state_d = ST_TRAP;
              cause_d = CAUSE_ECALL;
            end else if (is_ebreak) begin
              state_d = ST_HALT;
            end else begin
              state_d = ST_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC: begin
        if (cls_q == CLS_LOAD)       state_d = ST_MEM_RD;
        else if (cls_q == CLS_STORE) state_d = ST_MEM_WR;
        else                         state_d = ST_WB;
      end
      ST_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT, ST_TRAP:          state_d = state_q;
      default:                   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_NONE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
    end
  end

  // Output decode is gated by rst so strobes drop within the reset cycle itself.
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.pc_src       = PCSRC_ALU;
    bus.alu_src_a    = SRCA_RS1;
    bus.alu_src_b    = SRCB_RS2;
    bus.result_src   = RES_ALU;
    bus.alu_op       = ALUOP_ADD;
    bus.imm_src      = IMM_I;
    bus.halt         = 1'b0;
    bus.trap         = 1'b0;
    bus.trap_cause   = CAUSE_NONE;
    bus.state        = 4'd0;
    if (!rst) begin
      bus.state      = state_q;
      bus.halt       = (state_q == ST_HALT);
      bus.trap       = (state_q == ST_TRAP);
      bus.trap_cause = cause_q;
      // ALU setup stays applied until the result is consumed (address or writeback).
      if ((state_q == ST_EXEC) || (state_q == ST_MEM_RD) ||
          (state_q == ST_MEM_WR) || (state_q == ST_WB)) begin
        case (cls_q)
          CLS_ALUREG: bus.alu_op = ALUOP_FUNCT;
          CLS_ALUIMM: begin bus.alu_src_b = SRCB_IMM; bus.alu_op = ALUOP_FUNCT; end
          CLS_LOAD:   bus.alu_src_b = SRCB_IMM;
          CLS_STORE:  begin bus.alu_src_b = SRCB_IMM; bus.imm_src = IMM_S; end
          CLS_LUI: begin
            bus.alu_src_a = SRCA_ZERO;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_op    = ALUOP_PASSB;
            bus.imm_src   = IMM_U;
          end
          CLS_AUIPC: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_IMM;
            bus.imm_src   = IMM_U;
          end
          default: ;
        endcase
      end
      case (state_q)
        ST_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_a = SRCA_PC;
          bus.alu_src_b = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        ST_MEM_RD: begin bus.mem_read = 1'b1; bus.mem_addr_sel = 1'b1; end
        ST_MEM_WR: begin bus.mem_write = 1'b1; bus.mem_addr_sel = 1'b1; end
        ST_WB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = (cls_q == CLS_LOAD) ? RES_MEM : RES_ALU;
        end
        ST_BRANCH: begin
          bus.alu_op   = ALUOP_BRANCH;
          bus.imm_src  = IMM_B;
          bus.pc_src   = PCSRC_TARGET;
          bus.pc_write = bus.branch_taken;
        end
        ST_JUMP: begin
          bus.reg_write  = 1'b1;
          bus.result_src = RES_PC4;
          bus.pc_write   = 1'b1;
          if (cls_q == CLS_JALR) begin
            bus.alu_src_b = SRCB_IMM;
            bus.pc_src    = PCSRC_JALR;
            bus.imm_src   = IMM_I;
          end else begin
            bus.pc_src  = PCSRC_TARGET;
            bus.imm_src = IMM_J;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state/strobe traces for each
// instruction class, memory timeout, SYSTEM handling and reset mid-access.
module tb_multicycle_control;
  localparam int TO = 4;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2, S_MEM_RD = 4'd3,
                         S_MEM_WR = 4'd4, S_WB = 4'd5, S_BRANCH = 4'd6, S_JUMP = 4'd7,
                         S_HALT = 4'd8, S_TRAP = 4'd9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.DATA_WIDTH(32)) bus ();
  multicycle_control #(.DATA_WIDTH(32), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  // {pc_write, ir_write, reg_write, mem_read, mem_write}
  wire [4:0]  strobes = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write};
  wire [3:0]  flags   = {bus.halt, bus.trap, bus.trap_cause};
  wire [26:0] all_outs = {strobes, bus.mem_addr_sel, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                          bus.result_src, bus.alu_op, bus.imm_src, flags, bus.state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [3:0] st, input logic [4:0] sb);
    @(negedge clk);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".strobes"}, 32'(strobes), 32'(sb));
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [4:0] sb);
    look(tag, st, sb);
    step();
  endtask

  task automatic clr_in();
    bus.instr = 32'h0;
    {bus.alu_reg, bus.alu_imm, bus.branch, bus.jal, bus.jalr} = 5'b0;
    {bus.lui, bus.auipc, bus.load, bus.store, bus.system} = 5'b0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check({tag, ".rst_outs"}, 32'(all_outs), 32'h0);
    step();
    rst = 1'b0;
    clr_in();
    check({tag, ".rst_state"}, 32'(bus.state), 32'(S_FETCH));
    check({tag, ".rst_flags"}, 32'(flags), 32'h0);
  endtask

  initial begin
    clr_in();
    do_reset("init");

    // ADD x3,x1,x2 with zero-wait memory
    bus.instr = 32'h002081B3; bus.alu_reg = 1'b1; bus.mem_ready = 1'b1;
    look("add.f", S_FETCH, 5'b11010);
    check("add.f.sel", 32'({bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op}), 32'(8'b00_01_10_00));
    step();
    cyc("add.d", S_DECODE, 5'b00000);
    look("add.e", S_EXEC, 5'b00000);
    check("add.e.alu", 32'({bus.alu_src_a, bus.alu_src_b, bus.alu_op}), 32'(6'b00_00_10));
    step();
    look("add.wb", S_WB, 5'b00100);
    check("add.wb.res", 32'(bus.result_src), 32'(2'b00));
    step();

    // LW with three wait cycles in MEM_RD
    clr_in(); bus.instr = 32'h0000A183; bus.load = 1'b1; bus.mem_ready = 1'b1;
    cyc("lw.f", S_FETCH, 5'b11010);
    cyc("lw.d", S_DECODE, 5'b00000);
    look("lw.e", S_EXEC, 5'b00000);
    check("lw.e.alu", 32'({bus.alu_src_b, bus.alu_op, bus.imm_src}), 32'(7'b01_00_000));
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look("lw.rdwait", S_MEM_RD, 5'b00010);
      check("lw.rd.addrsel", 32'(bus.mem_addr_sel), 32'd1);
      step();
    end
    bus.mem_ready = 1'b1;
    cyc("lw.rd", S_MEM_RD, 5'b00010);
    look("lw.wb", S_WB, 5'b00100);
    check("lw.wb.res", 32'(bus.result_src), 32'(2'b01));
    step();

    // SW
    clr_in(); bus.instr = 32'h0020A023; bus.store = 1'b1; bus.mem_ready = 1'b1;
    cyc("sw.f", S_FETCH, 5'b11010);
    cyc("sw.d", S_DECODE, 5'b00000);
    look("sw.e", S_EXEC, 5'b00000);
    check("sw.e.imm", 32'({bus.alu_src_b, bus.imm_src}), 32'(5'b01_001));
    step();
    look("sw.wr", S_MEM_WR, 5'b00001);
    check("sw.wr.addrsel", 32'(bus.mem_addr_sel), 32'd1);
    step();

    // BEQ taken, then not taken
    clr_in(); bus.instr = 32'h00208463; bus.branch = 1'b1; bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b1;
    cyc("beq1.f", S_FETCH, 5'b11010);
    cyc("beq1.d", S_DECODE, 5'b00000);
    look("beq1.br", S_BRANCH, 5'b10000);
    check("beq1.sel", 32'({bus.pc_src, bus.alu_op, bus.imm_src}), 32'(7'b01_01_010));
    step();
    bus.branch_taken = 1'b0;
    cyc("beq0.f", S_FETCH, 5'b11010);
    cyc("beq0.d", S_DECODE, 5'b00000);
    cyc("beq0.br", S_BRANCH, 5'b00000);

    // JAL and JALR both set: JAL wins
    clr_in(); bus.jal = 1'b1; bus.jalr = 1'b1; bus.mem_ready = 1'b1;
    cyc("jal.f", S_FETCH, 5'b11010);
    cyc("jal.d", S_DECODE, 5'b00000);
    look("jal.j", S_JUMP, 5'b10100);
    check("jal.sel", 32'({bus.pc_src, bus.result_src, bus.imm_src}), 32'(7'b01_10_100));
    step();

    clr_in(); bus.jalr = 1'b1; bus.mem_ready = 1'b1;
    cyc("jalr.f", S_FETCH, 5'b11010);
    cyc("jalr.d", S_DECODE, 5'b00000);
    look("jalr.j", S_JUMP, 5'b10100);
    check("jalr.sel", 32'({bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src}), 32'(9'b10_00_01_000));
    step();

    // LUI
    clr_in(); bus.lui = 1'b1; bus.mem_ready = 1'b1;
    cyc("lui.f", S_FETCH, 5'b11010);
    cyc("lui.d", S_DECODE, 5'b00000);
    look("lui.e", S_EXEC, 5'b00000);
    check("lui.alu", 32'({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src}), 32'(9'b11_01_11_011));
    step();
    cyc("lui.wb", S_WB, 5'b00100);

    // Load and ALUreg both set: load path wins
    clr_in(); bus.load = 1'b1; bus.alu_reg = 1'b1; bus.mem_ready = 1'b1;
    cyc("prio.f", S_FETCH, 5'b11010);
    cyc("prio.d", S_DECODE, 5'b00000);
    cyc("prio.e", S_EXEC, 5'b00000);
    cyc("prio.rd", S_MEM_RD, 5'b00010);
    cyc("prio.wb", S_WB, 5'b00100);

    // Ready arrives on the 5th wait cycle: no trap
    clr_in(); bus.alu_reg = 1'b1;
    for (int i = 0; i < 4; i++) cyc("to_ok.wait", S_FETCH, 5'b00010);
    bus.mem_ready = 1'b1;
    cyc("to_ok.f", S_FETCH, 5'b11010);
    cyc("to_ok.d", S_DECODE, 5'b00000);
    cyc("to_ok.e", S_EXEC, 5'b00000);
    cyc("to_ok.wb", S_WB, 5'b00100);

    // Ready stuck low in FETCH: bus-timeout trap after the 5th wait cycle
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc("to.wait", S_FETCH, 5'b00010);
    look("to.trap", S_TRAP, 5'b00000);
    check("to.flags", 32'(flags), 32'(4'b0111));
    step();
    bus.mem_ready = 1'b1;
    look("to.hold", S_TRAP, 5'b00000);
    check("to.hold.flags", 32'(flags), 32'(4'b0111));
    do_reset("to");

    // ECALL
    bus.system = 1'b1; bus.instr = 32'h00000073; bus.mem_ready = 1'b1;
    cyc("ecall.f", S_FETCH, 5'b11010);
    cyc("ecall.d", S_DECODE, 5'b00000);
    look("ecall.t", S_TRAP, 5'b00000);
    check("ecall.flags", 32'(flags), 32'(4'b0110));
    do_reset("ecall");

    // Unrecognised SYSTEM instruction
    bus.system = 1'b1; bus.instr = 32'h30200073; bus.mem_ready = 1'b1;
    cyc("sysill.f", S_FETCH, 5'b11010);
    cyc("sysill.d", S_DECODE, 5'b00000);
    look("sysill.t", S_TRAP, 5'b00000);
    check("sysill.flags", 32'(flags), 32'(4'b0101));
    do_reset("sysill");

    // EBREAK halts until reset
    bus.system = 1'b1; bus.instr = 32'h00100073; bus.mem_ready = 1'b1;
    cyc("ebreak.f", S_FETCH, 5'b11010);
    cyc("ebreak.d", S_DECODE, 5'b00000);
    look("ebreak.h", S_HALT, 5'b00000);
    check("ebreak.flags", 32'(flags), 32'(4'b1000));
    step();
    for (int i = 0; i < 3; i++) cyc("ebreak.hold", S_HALT, 5'b00000);
    do_reset("ebreak");

    // No class bit set
    bus.mem_ready = 1'b1;
    cyc("none.f", S_FETCH, 5'b11010);
    cyc("none.d", S_DECODE, 5'b00000);
    look("none.t", S_TRAP, 5'b00000);
    check("none.flags", 32'(flags), 32'(4'b0101));
    do_reset("none");

    // Reset asserted while a store waits in MEM_WR
    bus.store = 1'b1; bus.mem_ready = 1'b1;
    cyc("rstwr.f", S_FETCH, 5'b11010);
    cyc("rstwr.d", S_DECODE, 5'b00000);
    cyc("rstwr.e", S_EXEC, 5'b00000);
    bus.mem_ready = 1'b0;
    cyc("rstwr.wr", S_MEM_WR, 5'b00001);
    do_reset("rstwr");
    look("rstwr.after", S_FETCH, 5'b00010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
